// File: rtl/led_code_scheduler.sv
// led_code_scheduler
//   Time-shares one status LED among NUM_REQ requesters. A round-robin arbiter
//   grants one requester at a time. The granted blink code N is played as N
//   timed pulses followed by an inter-code gap, and the requester is then
//   acknowledged.
//
// Optional feature: define LED_SEQ_ABORT_EN to let a requester cancel its own
//   sequence by dropping req while pulses are still playing. The gap is still
//   played, and no ack is issued for the cancelled code.
//
// Ports:
//   clk       in   single clock
//   rst       in   asynchronous, active-high reset
//   req       in   [NUM_REQ]         level request per requester
//   code      in   [NUM_REQ*CODE_W]  requester i code at [i*CODE_W +: CODE_W]
//   ack       out  [NUM_REQ]         one-cycle pulse when the served code completes
//   busy      out                    high while a code is being played
//   grant_id  out  [clog2(NUM_REQ)]  current or last served requester
//   led       out                    LED drive, active-high
module led_code_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int CODE_W    = 4,
    parameter int TICK_DIV  = 5000000,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 3,
    parameter int GAP_TICKS = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CODE_W-1:0]  code,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       led
);

    localparam int IDW     = $clog2(NUM_REQ);
    localparam int ON_CYC  = ON_TICKS * TICK_DIV;
    localparam int OFF_CYC = OFF_TICKS * TICK_DIV;
    localparam int GAP_CYC = GAP_TICKS * TICK_DIV;
    localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ((ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC)
                                                : ((OFF_CYC > GAP_CYC) ? OFF_CYC : GAP_CYC);
    localparam int TW      = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_e;

    state_e              state_q;
    logic [TW-1:0]       timer_q;
    logic [CODE_W-1:0]   cnt_q;
    logic [IDW-1:0]      last_q;
    logic                ab_q;     // current code was cancelled, so suppress its ack

    logic                found;
    logic [IDW-1:0]      win;
    logic [IDW-1:0]      cand;
    logic [CODE_W-1:0]   sel_code;
    logic [TW-1:0]       ph_last;
    logic                ph_done;
    logic                abort_now;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(last_q) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        sel_code = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == win) sel_code = code[i*CODE_W +: CODE_W];
        end
    end

    // Timer restarts at 0 on every state entry, so a phase of L cycles ends
    // on the edge where the timer has reached L-1.
    always_comb begin
        case (state_q)
            ON:      ph_last = TW'(ON_CYC - 1);
            OFF:     ph_last = TW'(OFF_CYC - 1);
            default: ph_last = TW'(GAP_CYC - 1);
        endcase
    end
    assign ph_done = (timer_q == ph_last);

`ifdef LED_SEQ_ABORT_EN
    assign abort_now = !req[grant_id];
`else
    assign abort_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            cnt_q    <= '0;
            last_q   <= IDW'(NUM_REQ - 1);
            ab_q     <= 1'b0;
            ack      <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            led      <= 1'b0;
        end else begin
            ack     <= '0;
            timer_q <= timer_q + 1'b1;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (found) begin
                        grant_id <= win;
                        last_q   <= win;
                        cnt_q    <= sel_code;
                        busy     <= 1'b1;
                        ab_q     <= 1'b0;
                        if (sel_code != '0) begin
                            led     <= 1'b1;
                            state_q <= ON;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                ON: begin
                    if (abort_now) begin
                        led     <= 1'b0;
                        ab_q    <= 1'b1;
                        timer_q <= '0;
                        state_q <= GAP;
                    end else if (ph_done) begin
                        led     <= 1'b0;
                        timer_q <= '0;
                        cnt_q   <= cnt_q - 1'b1;
                        // Counter value before the decrement: 1 means this was the last pulse.
                        state_q <= (cnt_q != CODE_W'(1)) ? OFF : GAP;
                    end
                end
                OFF: begin
                    if (abort_now) begin
                        ab_q    <= 1'b1;
                        timer_q <= '0;
                        state_q <= GAP;
                    end else if (ph_done) begin
                        led     <= 1'b1;
                        timer_q <= '0;
                        state_q <= ON;
                    end
                end
                GAP: begin
                    if (ph_done) begin
                        if (!ab_q) ack[grant_id] <= 1'b1;
                        busy    <= 1'b0;
                        timer_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/led_code_scheduler.md
# led_code_scheduler

Time-shares one board status LED among `NUM_REQ` requesters, each wanting to flash a numeric blink code. The scheduler grants requesters round-robin, plays the granted code as N timed pulses followed by an inter-code gap, then acknowledges. It sits between status sources and the LED pin and owns all LED timing, so sources only raise a request and present a code.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `CODE_W`, 4: width of each blink code; max code `2**CODE_W-1`.
- `TICK_DIV`, 5000000: clock cycles per tick (100 ms at 50 MHz).
- `ON_TICKS`, 2: ticks LED is on per pulse (>=1).
- `OFF_TICKS`, 3: ticks LED is off between pulses (>=1).
- `GAP_TICKS`, 10: ticks LED is off after the last pulse (>=1).

Ports:
- `clk` in 1: single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `req` in `NUM_REQ`: level request per requester.
- `code` in `NUM_REQ*CODE_W`: requester i's code is at `[i*CODE_W +: CODE_W]`.
- `ack` out `NUM_REQ`: one-cycle pulse on the served requester's bit when its code completes.
- `busy` out 1: high while a code is being played.
- `grant_id` out `$clog2(NUM_REQ)`: index of the current or last served requester.
- `led` out 1: LED drive, active-high.

## Operation
- FSM states: IDLE, ON, OFF, GAP.
- Round-robin pointer `last`. Search order is `last+1`, `last+2`, … modulo `NUM_REQ`. Reset sets `last = NUM_REQ-1`, so requester 0 has first priority.
- IDLE, any `req` bit high at a clock edge:
  - The first requester in search order wins; `grant_id` and `last` take its index.
  - Its code is latched into the pulse counter and `busy` is set.
  - If the latched code is nonzero: `led` is set and the FSM enters ON.
  - If the latched code is 0: no pulses; the FSM enters GAP with `led` low.
- ON: after `ON_TICKS*TICK_DIV` cycles, `led` is cleared and the pulse counter decrements. If the counter is still nonzero, the FSM enters OFF; otherwise it enters GAP.
- OFF: after `OFF_TICKS*TICK_DIV` cycles, `led` is set and the FSM enters ON.
- GAP: after `GAP_TICKS*TICK_DIV` cycles:
  - `ack[grant_id]` pulses for one cycle, `busy` clears, and the FSM enters IDLE.
  - IDLE always lasts at least one cycle before the next grant.
- Phase timer:
  - Single cycle counter, cleared on every state entry.
  - Width is `$clog2(max(ON,OFF,GAP)*TICK_DIV+1)`.
  - No free-running prescaler, so every phase length is exact.
- While busy, `code` and `req` changes are ignored and the latched code governs. Dropping `req` mid-sequence does not shorten it (unless the abort feature below is enabled).
- A requester holding `req` after its `ack` is re-queued; it is served again only after the others in round-robin order.
- Reset (asynchronous, any state): FSM goes to IDLE; `led`, `busy`, `ack` = 0; `grant_id` = 0; `last = NUM_REQ-1`; timer and pulse counter = 0.

## Timing
- All outputs are registered.
- Grant latency: `req` high at edge k in IDLE gives `led`, `busy` and `grant_id` valid after edge k.
- Sequence length for code N ≥ 1: `(N*ON_TICKS + (N-1)*OFF_TICKS + GAP_TICKS)*TICK_DIV` cycles from the grant edge to the `ack` edge.
- Sequence length for code 0: `GAP_TICKS*TICK_DIV` cycles.
- `ack` and `busy` deassertion occur on the same edge.
- Simultaneous requests are resolved purely by the pointer, never by index alone.

## Configuration
- `LED_SEQ_ABORT_EN` defined:
  - In ON or OFF, if `req[grant_id]` is low at an edge, `led` clears, the FSM enters GAP, and no `ack` is issued for that requester.
  - The gap is still played, so inter-code spacing is preserved.
- `LED_SEQ_ABORT_EN` undefined: `req` is not sampled while busy, and every granted code runs to completion with `ack`.

## Test plan
Parameters for all scenarios: `TICK_DIV=4`, `ON=1`, `OFF=1`, `GAP=2`, `NUM_REQ=4`.
- Single code: `req0`, `code0=3` → LED high 4 cycles / low 4 / high 4 / low 4 / high 4, then low 8; `ack[0]` pulses 28 cycles after grant; `busy` high for those 28 cycles.
- Code 0: `req2`, `code2=0` → LED stays 0; `ack[2]` 8 cycles after grant; `grant_id=2`.
- Round-robin: `req=4'b1111` held, all codes 1 → grant order 0, 1, 2, 3, 0; each `ack` is 12 cycles after its grant; each new grant is ≥1 idle cycle after the previous `ack`.
- Latching: grant `req1` with `code1=2`, change `code1` to 5 and drop `req1` mid-sequence → exactly 2 pulses and `ack[1]` still issued (abort off).
- Async reset: assert `rst` during second ON of a code-3 sequence → `led`/`busy` go to 0 immediately without a clock edge. After release, `req3` alone is granted, and with `req0`+`req3` together, requester 0 is granted first.
- Abort (`LED_SEQ_ABORT_EN`): drop `req0` during first OFF of a code-3 sequence → LED stays low, 8-cycle gap, no `ack[0]`, then IDLE.
